// File: rtl/ayatsuki_dbus_bridge.sv
// ayatsuki_dbus_bridge: core mem strobes to req/gnt/rvalid bus, one access in flight, optional timeout.
// Optional timeout build: define AYATSUKI_DBUS_TIMEOUT_EN.
module ayatsuki_dbus_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enable_i,
  input  logic              mem_w_enable_i,
  input  logic              mem_r_enable_i,
  input  logic [ADDR_W-1:0] mem_w_addr_i,
  input  logic [ADDR_W-1:0] mem_r_addr_i,
  input  logic [DATA_W-1:0] mem_w_data_i,
  output logic [DATA_W-1:0] mem_r_data_o,
  output logic              hold_req_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic new_access, busy, rd_done, done;
  assign new_access = mem_enable_i & (mem_w_enable_i | mem_r_enable_i);
  assign sel_addr = mem_w_enable_i ? mem_w_addr_i : mem_r_addr_i;
  assign busy = (state_q == REQ) | (state_q == WAIT_R);
  assign rd_done = bus_rvalid_i & (((state_q == REQ) & bus_gnt_i & ~we_q) | (state_q == WAIT_R));
  assign done = ((state_q == REQ) & bus_gnt_i & we_q) | rd_done;
  assign hold_req_o = ((state_q == IDLE) & new_access) | busy;
  assign bus_req_o = req_q;
  assign bus_we_o = we_q;
  assign bus_addr_o = addr_q;
  assign bus_wdata_o = wdata_q;
  assign mem_r_data_o = rdata_q;
`ifdef AYATSUKI_DBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, tmo;
  // the TIMEOUT-th busy cycle expires unless it completes normally
  assign tmo = busy & ~done & ((cnt_q + 1'b1) == CW'(TIMEOUT));
  assign cnt_d = busy ? cnt_q + 1'b1 : '0;
  assign bus_err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign bus_err_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rd_done ? bus_rdata_i : rdata_q;
`ifdef AYATSUKI_DBUS_TIMEOUT_EN
    err_d = err_q | tmo;
`endif
    case (state_q)
      IDLE: if (new_access) begin
        state_d = REQ;
        req_d = 1'b1;
        we_d = mem_w_enable_i;
        addr_d = sel_addr & ~ADDR_W'(3);
        wdata_d = mem_w_data_i;
      end
      REQ: if (bus_gnt_i) begin
        req_d = 1'b0;
        state_d = (we_q | bus_rvalid_i) ? DONE : WAIT_R;
      end
      WAIT_R: state_d = bus_rvalid_i ? DONE : WAIT_R;
      DONE: state_d = IDLE;
    endcase
`ifdef AYATSUKI_DBUS_TIMEOUT_EN
    if (tmo) begin
      state_d = DONE;
      req_d = 1'b0;
      rdata_d = we_q ? rdata_q : DATA_W'(32'hDEAD_BEEF);
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef AYATSUKI_DBUS_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef AYATSUKI_DBUS_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
endmodule
